scc_bus_initiator: RTL and testbench
====================================

Name: scc_bus_initiator

Overview:
- Bus master for the SCC-compatible wave-table slave's CPU-side interface (req/ack/wrt/adr/dbo/dbi, 16-bit address, 8-bit data).
- Accepts queued register read/write commands on a valid/ready port and buffers them in a small FIFO.
- Runs one bus transaction at a time with the req/ack handshake, enforces an idle gap between transactions, and returns read data on a response port.
- Sits between a player/sequencer (or test controller) and the SCC slave, all in the clk21m domain.

Parameters:
- FIFO_DEPTH, 8: command FIFO entries; power of 2, minimum 2.
- IDLE_GAP, 7: extra cycles bus_req stays low after a transaction completes (0 allowed).
- ACK_TIMEOUT, 255: max cycles bus_req is held waiting for ack. Used only with the optional feature.

Ports:
- clk21m  in  1  system clock, 21.47727 MHz
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command (= not full)
- cmd_wrt  in  1  1 = write, 0 = read
- cmd_adr  in  16  bus address
- cmd_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: read completed
- rsp_data  out  8  read data, valid with rsp_valid
- rsp_err  out  1  valid with rsp_valid; 1 = timed-out read
- busy  out  1  FIFO non-empty or state != IDLE
- bus_req  out  1  request to slave
- bus_ack  in  1  slave acknowledge
- bus_wrt  out  1  write strobe qualifier
- bus_adr  out  16  address to slave
- bus_wdata  out  8  data to slave (slave's dbo)
- bus_rdata  in  8  data from slave (slave's dbi)

Behaviour:
- Reset, asynchronous and immediate:
  - bus_req=0, bus_wrt=0, bus_adr=0, bus_wdata=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, cmd_ready=1.
  - FIFO emptied, state=IDLE, counters cleared.
  - Asserting reset mid-transaction drops bus_req at once and discards all queued commands.
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - Not fall-through: a command pushed into an empty FIFO is popped no earlier than the next cycle.
  - Push and pop in the same cycle is legal and leaves the count unchanged.
  - Pop only in IDLE.
- States:
  - IDLE: if FIFO non-empty, pop. On the next edge bus_req=1 and bus_wrt, bus_adr, bus_wdata are loaded from the entry; go to REQ.
  - REQ: bus_req, bus_wrt, bus_adr and bus_wdata are held stable. On the edge where bus_ack=1 is sampled:
    - bus_req=0 and bus_wrt=0.
    - For a read: rsp_valid=1 for exactly one cycle, rsp_data=bus_rdata as sampled that edge, rsp_err=0.
    - bus_adr and bus_wdata return to 0.
    - Go to GAP with gap counter = IDLE_GAP, or to IDLE if IDLE_GAP=0.
  - GAP: decrement each cycle; at 0 go to IDLE.
- Timing:
  - bus_req low time between back-to-back transactions is exactly IDLE_GAP+1 cycles.
  - bus_ack seen in the same cycle bus_req rises counts: a minimum transaction is 1 cycle of req.
  - bus_ack while not in REQ is ignored.
- Writes produce no response.
- Response ordering equals command order.
- busy is registered and deasserts the cycle after returning to IDLE with an empty FIFO.

Optional Feature:
- Macro: SCC_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ. If ACK_TIMEOUT cycles elapse with no ack, bus_req drops exactly as for an ack and the block enters GAP.
  - A timed-out read pulses rsp_valid with rsp_data=8'hFF and rsp_err=1.
  - A timed-out write is dropped silently, except that rsp_err pulses for one cycle with rsp_valid=0.
- Not defined:
  - REQ waits indefinitely and rsp_err is tied to 0.
  - ACK_TIMEOUT is unused.

Test Plan:
- Write: push write 0x9000/0x3F, slave acks 2 cycles after bus_req rises.
  - bus_req high 3 cycles with adr=9000, wrt=1, wdata=3F.
  - No rsp_valid; busy clears after the gap.
- Read: push read 0x9800, slave drives bus_rdata=0x7F with ack.
  - One rsp_valid pulse with rsp_data=7F, rsp_err=0.
  - Then read 0x9810 with rdata=00 returns rsp_data=00.
- Back-to-back: push 128 writes (0x9800–0x987F) with ack tied high.
  - Every command appears on the bus in order.
  - bus_req low exactly 8 cycles between transactions.
  - No command lost when cmd_ready stalls.
- Full: hold bus_ack=0 and push continuously.
  - Exactly FIFO_DEPTH+1 = 9 commands accepted before cmd_ready stays 0.
  - Releasing ack drains all 9 in order.
- Timeout (SCC_BUS_TIMEOUT_EN): read 0x9880 with no ack.
  - bus_req drops after 255 cycles.
  - rsp_valid=1, rsp_data=FF, rsp_err=1.
  - Next queued command proceeds normally.
- Reset mid-op: assert reset while bus_req=1 with 3 commands queued.
  - bus_req=0 immediately and busy=0.
  - After release no transaction occurs and cmd_ready=1.

Source files
------------

// File: rtl/scc_bus_initiator.sv
// rtl/scc_bus_initiator.sv - queued req/ack bus master for the SCC wave-table slave
// Optional ack timeout: define SCC_BUS_TIMEOUT_EN.
module scc_bus_initiator #(
  parameter int FIFO_DEPTH  = 8,
  parameter int IDLE_GAP    = 7,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wrt,
  input  logic [15:0] cmd_adr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        bus_wrt,
  output logic [15:0] bus_adr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  typedef struct packed {
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic          push;
  logic          pop;
  logic          timed_out;
  logic          done;

  assign cmd_ready = (count != (AW+1)'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk21m) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{wrt: cmd_wrt, adr: cmd_adr, wdata: cmd_wdata};
    end
  end

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SCC_BUS_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Counter value k means k+1 cycles of req have been sampled without ack.
  assign timed_out = (state == REQ) && !bus_ack && (to_cnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != REQ) begin
      to_cnt <= '0;
    end else if (!timed_out) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^ACK_TIMEOUT;
  assign timed_out          = 1'b0;
`endif

  assign done = (state == REQ) && (bus_ack || timed_out);

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      bus_req   <= 1'b0;
      bus_wrt   <= 1'b0;
      bus_adr   <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= (count != '0) || (state != IDLE);
      case (state)
        IDLE: begin
          if (pop) begin
            bus_req   <= 1'b1;
            bus_wrt   <= head.wrt;
            bus_adr   <= head.adr;
            bus_wdata <= head.wdata;
            state     <= REQ;
          end
        end
        REQ: begin
          if (done) begin
            bus_req   <= 1'b0;
            bus_wrt   <= 1'b0;
            bus_adr   <= '0;
            bus_wdata <= '0;
            rsp_err   <= timed_out;
            if (!bus_wrt) begin
              rsp_valid <= 1'b1;
              rsp_data  <= timed_out ? 8'hFF : bus_rdata;
            end
            if (IDLE_GAP == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= GW'(IDLE_GAP);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          // Leaving on the count of 1 makes req low exactly IDLE_GAP+1 cycles.
          if (gap_cnt <= GW'(1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scc_bus_initiator.sv
// tb/tb_scc_bus_initiator.sv - randomized self-checking bench for scc_bus_initiator
`timescale 1ns/1ps
module tb_scc_bus_initiator;

  localparam int FIFO_DEPTH  = 8;
  localparam int IDLE_GAP    = 7;
  localparam int ACK_TIMEOUT = 255;

  logic        clk21m = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wrt = 1'b0;
  logic [15:0] cmd_adr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        bus_req;
  logic        bus_ack = 1'b0;
  logic        bus_wrt;
  logic [15:0] bus_adr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #23 clk21m = ~clk21m;

  scc_bus_initiator #(
    .FIFO_DEPTH(FIFO_DEPTH), .IDLE_GAP(IDLE_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk21m(clk21m), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wrt(cmd_wrt),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_wrt(bus_wrt), .bus_adr(bus_adr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // Slave model: 0 never acks, 1 ack tied high, 2 fixed delay, 3 random delay per transaction.
  int ack_mode = 0;
  int ack_delay = 0;
  int cur_delay = 0;
  int req_age = 0;
  int exp_len_q[$];

  function automatic logic [7:0] slave_data(input logic [15:0] a);
    if (a == 16'h9800) return 8'h7F;
    if (a == 16'h9810) return 8'h00;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(negedge clk21m) begin
    if (bus_req) req_age = req_age + 1;
    else         req_age = 0;
    if (ack_mode == 3 && req_age == 1) begin
      cur_delay = $urandom_range(0, 4);
      exp_len_q.push_back(cur_delay + 1);
    end
    case (ack_mode)
      1:       bus_ack = 1'b1;
      2:       bus_ack = bus_req && (req_age >= ack_delay + 1);
      3:       bus_ack = bus_req && (req_age >= cur_delay + 1);
      default: bus_ack = 1'b0;
    endcase
    bus_rdata = slave_data(bus_adr);
  end

  // Bus monitor: records transactions, req high/low lengths and responses.
  logic [24:0] obs_q[$];
  logic [8:0]  rsp_q[$];
  int          hi_q[$];
  int          gap_q[$];
  int          hi_n = 0, lo_n = 0;
  int          bad_idle = 0, unstable = 0, rsp_double = 0, lone_err = 0;
  logic        prev_req = 1'b0, prev_rsp = 1'b0, have_prev = 1'b0, mon_clr = 1'b0;
  logic [24:0] cur = '0;

  always @(negedge clk21m) begin
    if (mon_clr) begin
      obs_q.delete(); rsp_q.delete(); hi_q.delete(); gap_q.delete();
      have_prev = 1'b0; bad_idle = 0; unstable = 0; rsp_double = 0; lone_err = 0;
    end
    if (bus_req && !prev_req) begin
      cur = {bus_wrt, bus_adr, bus_wdata};
      obs_q.push_back(cur);
      if (have_prev) gap_q.push_back(lo_n);
      hi_n = 0;
    end
    if (bus_req) begin
      hi_n = hi_n + 1;
      if ({bus_wrt, bus_adr, bus_wdata} != cur) unstable = unstable + 1;
    end else begin
      if (prev_req) begin
        hi_q.push_back(hi_n);
        have_prev = 1'b1;
        lo_n = 0;
      end
      lo_n = lo_n + 1;
      if (bus_wrt || bus_adr != 16'h0 || bus_wdata != 8'h0) bad_idle = bad_idle + 1;
    end
    if (rsp_valid) rsp_q.push_back({rsp_err, rsp_data});
    if (rsp_err && !rsp_valid) lone_err = lone_err + 1;
    if (rsp_valid && prev_rsp) rsp_double = rsp_double + 1;
    prev_rsp = rsp_valid;
    prev_req = bus_req;
  end

  logic [24:0] exp_q[$];

  // Index of first bus transaction differing from the accepted commands (-2: count differs).
  function automatic int order_diff();
    logic [24:0] m;
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) begin
      m = exp_q[i][24] ? 25'h1FFFFFF : 25'h1FFFF00;
      if ((obs_q[i] & m) !== (exp_q[i] & m)) return i;
    end
    return -1;
  endfunction

  function automatic int rsp_diff();
    logic [8:0] want[$];
    foreach (exp_q[i]) if (!exp_q[i][24]) want.push_back({1'b0, slave_data(exp_q[i][23:8])});
    if (want.size() != rsp_q.size()) return -2;
    foreach (want[i]) if (rsp_q[i] !== want[i]) return i;
    return -1;
  endfunction

  task automatic mon_clear();
    exp_q.delete();
    mon_clr = 1'b1;
    @(negedge clk21m);
    #1 mon_clr = 1'b0;
  endtask

  task automatic push_cmd(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk21m);
    cmd_valid = 1'b1; cmd_wrt = w; cmd_adr = a; cmd_wdata = d;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk21m);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_stall cmd_ready=%0b required 1 within 2000 cycles", cmd_ready);
    end else begin
      exp_q.push_back({w, a, d});
      @(posedge clk21m);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    repeat (3) @(negedge clk21m);
    while ((busy || bus_req) && n < bound) begin
      @(negedge clk21m);
      n++;
    end
    checks++;
    if (busy || bus_req) begin
      errors++;
      $display("FAIL idle_timeout busy=%0b bus_req=%0b required both 0 within %0d cycles", busy, bus_req, bound);
    end
    repeat (2) @(negedge clk21m);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk21m);
    checks++;
    if ({bus_req, bus_wrt, bus_adr, bus_wdata} !== 26'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h required 0", {bus_req, bus_wrt, bus_adr, bus_wdata});
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_err} !== 10'h0) begin
      errors++;
      $display("FAIL reset_rsp got=%h required 0", {rsp_valid, rsp_data, rsp_err});
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status busy=%b cmd_ready=%b required busy=0 cmd_ready=1", busy, cmd_ready);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk21m);
  endtask

  task automatic test_write();
    int n = 0;
    int tail = 0;
    mon_clear();
    ack_mode = 2; ack_delay = 2;
    push_cmd(1'b1, 16'h9000, 8'h3F);
    while (!bus_req && n < 20) begin @(negedge clk21m); n++; end
    while (bus_req && n < 40) begin @(negedge clk21m); n++; end
    while (busy && tail < 50) begin @(negedge clk21m); tail++; end
    wait_idle(100);
    checks++;
    if (obs_q.size() != 1 || (obs_q.size() > 0 && obs_q[0] !== {1'b1, 16'h9000, 8'h3F})) begin
      errors++;
      $display("FAIL write_bus got=%h (n=%0d) required %h", obs_q.size() > 0 ? obs_q[0] : 25'h0, obs_q.size(), {1'b1, 16'h9000, 8'h3F});
    end
    checks++;
    if ((hi_q.size() > 0 ? hi_q[0] : -1) !== 3) begin
      errors++;
      $display("FAIL write_req_len got=%0d required 3", hi_q.size() > 0 ? hi_q[0] : -1);
    end
    checks++;
    if (rsp_q.size() != 0 || lone_err != 0) begin
      errors++;
      $display("FAIL write_no_rsp got rsp=%0d lone_err=%0d required 0", rsp_q.size(), lone_err);
    end
    checks++;
    if (tail !== IDLE_GAP + 1) begin
      errors++;
      $display("FAIL write_busy_tail got=%0d required %0d", tail, IDLE_GAP + 1);
    end
  endtask

  task automatic test_read();
    mon_clear();
    ack_mode = 2; ack_delay = 0;
    push_cmd(1'b0, 16'h9800, 8'($urandom));
    push_cmd(1'b0, 16'h9810, 8'($urandom));
    wait_idle(200);
    checks++;
    if (rsp_q.size() != 2 || rsp_q[0] !== 9'h07F || rsp_q[1] !== 9'h000) begin
      errors++;
      $display("FAIL read_rsp got n=%0d first=%h second=%h required 07f 000", rsp_q.size(),
               rsp_q.size() > 0 ? rsp_q[0] : 9'h1FF, rsp_q.size() > 1 ? rsp_q[1] : 9'h1FF);
    end
    checks++;
    if (order_diff() != -1 || rsp_double != 0) begin
      errors++;
      $display("FAIL read_order got diff=%0d double=%0d required -1 0", order_diff(), rsp_double);
    end
  endtask

  task automatic test_back_to_back();
    int bad_gap = 0, bad_hi = 0;
    mon_clear();
    ack_mode = 1;
    for (int i = 0; i < 128; i++) push_cmd(1'b1, 16'h9800 + 16'(i), 8'($urandom));
    wait_idle(3000);
    foreach (gap_q[i]) if (gap_q[i] != IDLE_GAP + 1) bad_gap++;
    foreach (hi_q[i]) if (hi_q[i] != 1) bad_hi++;
    checks++;
    if (order_diff() != -1) begin
      errors++;
      $display("FAIL b2b_order got diff=%0d (obs=%0d) required -1 (128)", order_diff(), obs_q.size());
    end
    checks++;
    if (gap_q.size() != 127 || bad_gap != 0) begin
      errors++;
      $display("FAIL b2b_gap got n=%0d bad=%0d required 127 gaps of %0d", gap_q.size(), bad_gap, IDLE_GAP + 1);
    end
    checks++;
    if (bad_hi != 0 || rsp_q.size() != 0 || unstable != 0 || bad_idle != 0) begin
      errors++;
      $display("FAIL b2b_bus got bad_hi=%0d rsp=%0d unstable=%0d bad_idle=%0d required all 0", bad_hi, rsp_q.size(), unstable, bad_idle);
    end
  endtask

  task automatic test_full();
    int acc = 0;
    logic rdy, last_rdy;
    mon_clear();
    ack_mode = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk21m);
      cmd_valid = 1'b1;
      cmd_wrt = 1'($urandom_range(0, 1));
      cmd_adr = 16'hA000 + 16'(acc);
      cmd_wdata = 8'($urandom);
      rdy = cmd_ready;
      @(posedge clk21m);
      if (rdy) begin
        exp_q.push_back({cmd_wrt, cmd_adr, cmd_wdata});
        acc++;
      end
    end
    @(negedge clk21m);
    last_rdy = cmd_ready;
    cmd_valid = 1'b0;
    checks++;
    if (acc !== FIFO_DEPTH + 1 || last_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_accept got=%0d ready=%b required %0d ready=0", acc, last_rdy, FIFO_DEPTH + 1);
    end
    ack_mode = 1;
    wait_idle(500);
    checks++;
    if (order_diff() != -1 || rsp_diff() != -1) begin
      errors++;
      $display("FAIL full_drain got order=%0d rsp=%0d required -1 -1", order_diff(), rsp_diff());
    end
  endtask

  task automatic test_random();
    int base, bad_len = 0, short_gap = 0;
    mon_clear();
    base = exp_len_q.size();
    ack_mode = 3;
    for (int i = 0; i < 40; i++) begin
      push_cmd(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk21m);
    end
    wait_idle(2000);
    foreach (hi_q[i]) if (base + i >= exp_len_q.size() || hi_q[i] != exp_len_q[base + i]) bad_len++;
    foreach (gap_q[i]) if (gap_q[i] < IDLE_GAP + 1) short_gap++;
    checks++;
    if (order_diff() != -1) begin
      errors++;
      $display("FAIL random_order got diff=%0d required -1", order_diff());
    end
    checks++;
    if (rsp_diff() != -1 || rsp_double != 0) begin
      errors++;
      $display("FAIL random_rsp got diff=%0d double=%0d required -1 0", rsp_diff(), rsp_double);
    end
    checks++;
    if (bad_len != 0 || short_gap != 0 || hi_q.size() != 40) begin
      errors++;
      $display("FAIL random_timing got bad_len=%0d short_gap=%0d n=%0d required 0 0 40", bad_len, short_gap, hi_q.size());
    end
  endtask

`ifdef SCC_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    mon_clear();
    ack_mode = 0;
    push_cmd(1'b0, 16'h9880, 8'h00);
    push_cmd(1'b1, 16'h9881, 8'h55);
    while (hi_q.size() < 1 && n < 400) begin @(negedge clk21m); n++; end
    ack_mode = 1;
    wait_idle(200);
    checks++;
    if ((hi_q.size() > 0 ? hi_q[0] : -1) !== ACK_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len got=%0d required %0d", hi_q.size() > 0 ? hi_q[0] : -1, ACK_TIMEOUT);
    end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 9'h1FF) begin
      errors++;
      $display("FAIL timeout_rsp got n=%0d val=%h required 1 1ff", rsp_q.size(), rsp_q.size() > 0 ? rsp_q[0] : 9'h0);
    end
    checks++;
    if (order_diff() != -1 || (hi_q.size() > 1 ? hi_q[1] : -1) !== 1 || lone_err != 0) begin
      errors++;
      $display("FAIL timeout_next got order=%0d len=%0d lone_err=%0d required -1 1 0", order_diff(), hi_q.size() > 1 ? hi_q[1] : -1, lone_err);
    end
  endtask
`endif

  task automatic test_reset_midop();
    int n = 0;
    mon_clear();
    ack_mode = 0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 16'h9900 + 16'(i), 8'($urandom));
    while (!bus_req && n < 20) begin @(negedge clk21m); n++; end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midop got req=%b busy=%b ready=%b required 0 0 1", bus_req, busy, cmd_ready);
    end
    repeat (3) @(negedge clk21m);
    reset = 1'b0;
    mon_clear();
    ack_mode = 1;
    repeat (40) @(negedge clk21m);
    checks++;
    if (obs_q.size() != 0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got txns=%0d ready=%b busy=%b required 0 1 0", obs_q.size(), cmd_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_full();
    test_random();
`ifdef SCC_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
